// File: rtl/jtag_tdo_capture.sv
// Captures tdo bits on tck rising edges (after skipping TMS navigation edges) and packs them
// MSB-first into FIFO words; the final partial word is left-aligned and zero-padded.
module jtag_tdo_capture #(
  parameter int DATA_FIFO = 8,
  parameter int SKIP_MAX  = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [15:0]                       len,
  input  logic [$clog2(SKIP_MAX+1)-1:0]     skip,
  input  logic                              tck,
  input  logic                              tdo,
  output logic [DATA_FIFO-1:0]              wdata_data,
  output logic                              wr_data,
  input  logic                              full_data,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow
);

  localparam int SW = $clog2(SKIP_MAX + 1);
  localparam int PW = $clog2(DATA_FIFO + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(DATA_FIFO - 1);
  localparam logic [PW-1:0] POS_FULL = PW'(DATA_FIFO);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SKIP    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Left-align a partial word of pos valid bits, filling the low end with zeros.
  function automatic logic [DATA_FIFO-1:0] align_word(input logic [DATA_FIFO-1:0] sh,
                                                      input logic [PW-1:0] pos);
    align_word = sh << (POS_FULL - pos);
  endfunction

  state_t                 state_r, state_s;
  logic                   tck_q_r;
  logic                   rise_s;
  logic [15:0]            bit_cnt_r, bit_cnt_s;
  logic [SW-1:0]          skip_cnt_r, skip_cnt_s;
  logic [DATA_FIFO-1:0]   sh_r, sh_s;
  logic [PW-1:0]          pos_r, pos_s;
  logic [DATA_FIFO-1:0]   wdata_s;
  logic                   wr_s;
  logic                   busy_s;
  logic                   done_s;
  logic                   overflow_s;

  assign rise_s = tck & ~tck_q_r;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      tck_q_r    <= 1'b0;
      bit_cnt_r  <= 16'd0;
      skip_cnt_r <= '0;
      sh_r       <= '0;
      pos_r      <= '0;
      wdata_data <= '0;
      wr_data    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_r    <= state_s;
      tck_q_r    <= tck;
      bit_cnt_r  <= bit_cnt_s;
      skip_cnt_r <= skip_cnt_s;
      sh_r       <= sh_s;
      pos_r      <= pos_s;
      wdata_data <= wdata_s;
      wr_data    <= wr_s;
      busy       <= busy_s;
      done       <= done_s;
      overflow   <= overflow_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    skip_cnt_s = skip_cnt_r;
    sh_s       = sh_r;
    pos_s      = pos_r;
    wdata_s    = wdata_data;
    wr_s       = 1'b0;
    busy_s     = busy;
    done_s     = 1'b0;
    overflow_s = overflow;

    if (abort) begin
      // Abort beats everything, including a simultaneous start; overflow is kept.
      state_s = ST_IDLE;
      busy_s  = 1'b0;
      sh_s    = '0;
      pos_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_s = 1'b0;
          if (start) begin
            bit_cnt_s  = len;
            skip_cnt_s = skip;
            overflow_s = 1'b0;
            busy_s     = 1'b1;
            sh_s       = '0;
            pos_s      = '0;
            if (skip != '0) begin
              state_s = ST_SKIP;
            end else if (len != 16'd0) begin
              state_s = ST_CAPTURE;
            end else begin
              state_s = ST_DONE;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end

        ST_SKIP: begin
          if (rise_s) begin
            skip_cnt_s = skip_cnt_r - SW'(1);
            if (skip_cnt_r == SW'(1)) begin
              state_s = (bit_cnt_r != 16'd0) ? ST_CAPTURE : ST_DONE;
            end else begin
              state_s = ST_SKIP;
            end
          end else begin
            state_s = ST_SKIP;
          end
        end

        ST_CAPTURE: begin
          if (rise_s) begin
            sh_s      = {sh_r[DATA_FIFO-2:0], tdo};
            pos_s     = pos_r + PW'(1);
            bit_cnt_s = bit_cnt_r - 16'd1;
            if ((pos_r == POS_LAST) || (bit_cnt_r == 16'd1)) begin
              state_s = ST_WRITE;
            end else begin
              state_s = ST_CAPTURE;
            end
          end else begin
            state_s = ST_CAPTURE;
          end
        end

        ST_WRITE: begin
          wdata_s = align_word(sh_r, pos_r);
          if (full_data) begin
            overflow_s = 1'b1;
          end else begin
            wr_s = 1'b1;
          end
          // A rise landing here starts the next word so no bit is lost at fast tck.
          if (rise_s && (bit_cnt_r != 16'd0)) begin
            sh_s      = {{(DATA_FIFO-1){1'b0}}, tdo};
            pos_s     = PW'(1);
            bit_cnt_s = bit_cnt_r - 16'd1;
            state_s   = (bit_cnt_r == 16'd1) ? ST_WRITE : ST_CAPTURE;
          end else begin
            sh_s    = '0;
            pos_s   = '0;
            state_s = (bit_cnt_r != 16'd0) ? ST_CAPTURE : ST_DONE;
          end
        end

        ST_DONE: begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end

        default: begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          sh_s    = '0;
          pos_s   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tdo_capture.sv
// Directed bench for jtag_tdo_capture: a vector table of capture jobs plus hand-written
// sequences for abort, start-while-busy, overflow persistence and mid-capture reset.
module tb_jtag_tdo_capture;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] len;
  logic [3:0]  skip;
  logic        tck;
  logic        tdo;
  logic [7:0]  wdata_data;
  logic        wr_data;
  logic        full_data;
  logic        busy;
  logic        done;
  logic        overflow;

  jtag_tdo_capture #(.DATA_FIFO(8), .SKIP_MAX(15)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len), .skip(skip),
    .tck(tck), .tdo(tdo), .wdata_data(wdata_data), .wr_data(wr_data),
    .full_data(full_data), .busy(busy), .done(done), .overflow(overflow)
  );

  typedef struct {
    int          skip;
    int          len;
    int          half;       // tck half period in clk cycles
    logic [31:0] data;       // tdo bits, sent from bit 31 downward
    logic [3:0]  full_mask;  // full_data level while word k is being captured/written
    int          nw;
    logic [31:0] words;      // expected words, first at [31:24]
    logic        ovf;
  } vec_t;

  vec_t        vecs [8];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_wr_cyc = 0;
  int          rise_cyc = 0;
  logic [7:0]  wq [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe registered outputs mid-cycle.
  always @(negedge clk) begin
    if (wr_data) begin
      wq.push_back(wdata_data);
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (wr_data && done) begin
      fails = fails + 1;
      $display("FAIL wr_done_overlap: wr_data and done both high at cycle %0d", cyc);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int s, input int l);
    start = 1'b1;
    skip  = 4'(s);
    len   = 16'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic tck_bit(input logic b, input int half);
    tck = 1'b0;
    tdo = b;
    repeat (half) tick();
    tck = 1'b1;
    rise_cyc = cyc;
    repeat (half) tick();
  endtask

  task automatic wait_done(input int d0, input int bound);
    int n = 0;
    while (done_cnt == d0 && n < bound) begin
      tick();
      n++;
    end
    chk("done_arrived", (done_cnt != d0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int   d0;
    int   s_cyc;
    int   last_rise;
    v = vecs[k];
    wq.delete();
    d0 = done_cnt;
    last_rise = 0;
    full_data = v.full_mask[0];
    s_cyc = cyc;
    do_start(v.skip, v.len);
    chk($sformatf("v%0d_busy_after_start", k), {31'd0, busy}, 32'd1);
    chk($sformatf("v%0d_ovf_cleared", k), {31'd0, overflow}, 32'd0);
    for (int i = 0; i < v.skip; i++) tck_bit(~v.data[31], v.half);
    for (int i = 0; i < v.len; i++) begin
      full_data = v.full_mask[i / 8];
      tck_bit(v.data[31 - i], v.half);
      last_rise = rise_cyc;
    end
    tck = 1'b0;
    wait_done(d0, 40);
    tick();
    chk($sformatf("v%0d_nwrites", k), wq.size(), v.nw);
    for (int j = 0; j < v.nw; j++) begin
      chk($sformatf("v%0d_word%0d", k, j), (j < wq.size()) ? {24'd0, wq[j]} : 32'hFFFF_FFFF,
          {24'd0, v.words[31 - 8*j -: 8]});
    end
    chk($sformatf("v%0d_done_count", k), done_cnt, d0 + 1);
    chk($sformatf("v%0d_overflow", k), {31'd0, overflow}, {31'd0, v.ovf});
    chk($sformatf("v%0d_busy_end", k), {31'd0, busy}, 32'd0);
    if (v.len > 0) begin
      chk($sformatf("v%0d_wr_latency", k), last_wr_cyc, last_rise + 2);
      chk($sformatf("v%0d_done_latency", k), done_cyc, last_rise + 3);
    end else begin
      chk($sformatf("v%0d_done_latency", k), done_cyc, s_cyc + 2);
    end
    full_data = 1'b0;
  endtask

  initial begin
    int d0;
    vecs[0] = '{4, 8,  2, 32'hB200_0000, 4'b0000, 1, 32'hB200_0000, 1'b0};
    vecs[1] = '{4, 10, 2, 32'hFFFF_FFFF, 4'b0000, 2, 32'hFFC0_0000, 1'b0};
    vecs[2] = '{0, 16, 2, 32'hA55A_0000, 4'b0001, 1, 32'h5A00_0000, 1'b1};
    vecs[3] = '{0, 0,  2, 32'h0000_0000, 4'b0000, 0, 32'h0000_0000, 1'b0};
    vecs[4] = '{3, 13, 2, 32'h1234_5678, 4'b0000, 2, 32'h1230_0000, 1'b0};
    vecs[5] = '{1, 3,  3, 32'hE000_0000, 4'b0000, 1, 32'hE000_0000, 1'b0};
    vecs[6] = '{0, 17, 1, 32'hDEAD_BEEF, 4'b0000, 3, 32'hDEAD_8000, 1'b0};
    vecs[7] = '{2, 9,  1, 32'h5555_5555, 4'b0000, 2, 32'h5500_0000, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; len = 16'd0; skip = 4'd0;
    tck = 1'b0; tdo = 1'b0; full_data = 1'b0;
    repeat (2) tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_wr", {31'd0, wr_data}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    chk("reset_wdata", {24'd0, wdata_data}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    for (int k = 0; k < 8; k++) run_vec(k);

    // Overflow persists in idle and through a lone abort, until the next start.
    run_vec(2);
    repeat (3) tick();
    chk("ovf_sticky_idle", {31'd0, overflow}, 32'd1);
    abort = 1'b1; tick(); abort = 1'b0; tick();
    chk("ovf_kept_by_abort", {31'd0, overflow}, 32'd1);

    // Start while busy is ignored: the 8-bit job must not be replaced by len=2.
    wq.delete();
    d0 = done_cnt;
    do_start(0, 8);
    for (int i = 0; i < 3; i++) tck_bit(i < 2, 2);
    start = 1'b1; len = 16'd2; skip = 4'd3; tick(); start = 1'b0;
    for (int i = 3; i < 8; i++) tck_bit(i > 5, 2);
    tck = 1'b0;
    wait_done(d0, 40);
    tick();
    chk("busy_start_nwrites", wq.size(), 1);
    chk("busy_start_word", (wq.size() > 0) ? {24'd0, wq[0]} : 32'hFFFF_FFFF, 32'h0000_00C3);

    // Abort after 5 of 8 bits: no write, no done, idle next cycle.
    wq.delete();
    d0 = done_cnt;
    do_start(0, 8);
    for (int i = 0; i < 5; i++) tck_bit(1'b1, 2);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy_low", {31'd0, busy}, 32'd0);
    tck = 1'b0;
    repeat (10) tick();
    chk("abort_no_write", wq.size(), 0);
    chk("abort_no_done", done_cnt, d0);

    // Abort and start together: abort wins.
    start = 1'b1; abort = 1'b1; len = 16'd8; skip = 4'd0; tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    chk("abort_start_idle", {31'd0, busy}, 32'd0);
    run_vec(0);

    // Reset asserted between edges mid-capture, with a start held during reset.
    wq.delete();
    full_data = 1'b1;
    do_start(0, 16);
    for (int i = 0; i < 9; i++) tck_bit(1'b1, 2);
    chk("pre_reset_ovf", {31'd0, overflow}, 32'd1);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1; start = 1'b1; tck = 1'b0; full_data = 1'b0;
    #1;
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_async_wr", {31'd0, wr_data}, 32'd0);
    chk("rst_async_wdata", {24'd0, wdata_data}, 32'd0);
    tick();
    chk("rst_start_ignored", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    run_vec(4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
